// File: rtl/tt_probe_pkg.sv
// rtl/tt_probe_pkg.sv - shared FSM type, row count and row-to-bit mapping for the truth-table probe
package tt_probe_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int NUM_ROWS = 8;

  // Row 0 lands in the MSB so the code reads like the gate module hex names.
  function automatic logic [2:0] row_bit(input logic [2:0] row);
    return 3'(NUM_ROWS - 1) - row;
  endfunction

endpackage

// File: rtl/tt_row_sampler.sv
// rtl/tt_row_sampler.sv - settle/sample counting and sample agreement for one truth-table row
module tt_row_sampler #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned N_SAMPLES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic settling,
  input  logic sampling,
  input  logic sample_in,
  output logic settle_done,
  output logic bit_valid,
  output logic bit_value,
  output logic disagree
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int NW = $clog2(N_SAMPLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] SAMPLE_LAST = NW'(N_SAMPLES - 1);

  logic [SW-1:0] settle_cnt;
  logic [NW-1:0] sample_cnt;
  logic          first_q;
  logic          disagree_q;
  logic          first_sample;
  logic          mismatch;

  assign settle_done  = settling && (settle_cnt == SETTLE_LAST);
  assign first_sample = (sample_cnt == '0);
  assign bit_valid    = sampling && (sample_cnt == SAMPLE_LAST);
  // The reported bit is always the first sample, even when it is taken on the last cycle.
  assign bit_value    = first_sample ? sample_in : first_q;
  assign mismatch     = sampling && !first_sample && (sample_in != first_q);
  assign disagree     = disagree_q | mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= '0;
      sample_cnt <= '0;
      first_q    <= 1'b0;
      disagree_q <= 1'b0;
    end else begin
      settle_cnt <= (settling && !settle_done) ? settle_cnt + SW'(1) : '0;
      sample_cnt <= (sampling && !bit_valid) ? sample_cnt + NW'(1) : '0;
      if (sampling && first_sample) begin
        first_q <= sample_in;
      end
      disagree_q <= sampling && !bit_valid && disagree;
    end
  end

endmodule

// File: rtl/truth_table_probe.sv
// rtl/truth_table_probe.sv - sweeps all 8 input rows into a 3-input gate and rebuilds its truth-table code
module truth_table_probe
  import tt_probe_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned N_SAMPLES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic       unstable
);

  state_t     state_q, state_d;
  logic [2:0] row_q;
  logic [7:0] table_q;
  logic       unstable_q;
  logic       settle_done, bit_valid, bit_value, disagree;

  tt_row_sampler #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .N_SAMPLES    (N_SAMPLES)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .settling   (state_q == SETTLE),
    .sampling   (state_q == SAMPLE),
    .sample_in  (dut_out),
    .settle_done(settle_done),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .disagree   (disagree)
  );

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE: begin
        busy = 1'b1;
        if (settle_done) state_d = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (bit_valid) state_d = (row_q == 3'(NUM_ROWS - 1)) ? DONE : SETTLE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      table_q    <= '0;
      unstable_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        row_q      <= '0;
        table_q    <= '0;
        unstable_q <= 1'b0;
      end
      // Row 7 stays on the pins after the sweep; the FSM, not the counter, ends it.
      if (bit_valid) begin
        table_q[row_bit(row_q)] <= bit_value;
        unstable_q              <= unstable_q | disagree;
        if (row_q != 3'(NUM_ROWS - 1)) row_q <= row_q + 3'd1;
      end
    end
  end

  assign {in1, in2, in3} = row_q;
  assign table_code      = table_q;
  assign unstable        = unstable_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// tb/tb_truth_table_probe.sv - scoreboard bench for truth_table_probe with two parameter sets
module tb_truth_table_probe;
  import tt_probe_pkg::*;

  typedef struct {
    logic [7:0] code;
    logic       unst;
    int         done_cyc;
    int         busy_len;
  } exp_t;

  localparam int M_AND13 = 0, M_ZERO = 1, M_ONE = 2, M_XOR3 = 3, M_GLITCH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start [2];
  logic       in1 [2], in2 [2], in3 [2], dut_out [2];
  logic       busy [2], done [2], unstable [2];
  logic [7:0] code [2];

  int         mode [2];
  int         age [2];
  logic [2:0] last_row [2];
  exp_t       sb [2][$];
  int         busy_cnt [2];
  logic       prev_busy [2], prev_done [2];
  logic [2:0] busy_row [2];
  int         checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_probe #(.SETTLE_CYCLES(4), .N_SAMPLES(2)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]),
    .in1(in1[0]), .in2(in2[0]), .in3(in3[0]), .dut_out(dut_out[0]),
    .busy(busy[0]), .done(done[0]), .table_code(code[0]), .unstable(unstable[0])
  );

  truth_table_probe #(.SETTLE_CYCLES(1), .N_SAMPLES(1)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]),
    .in1(in1[1]), .in2(in2[1]), .in3(in3[1]), .dut_out(dut_out[1]),
    .busy(busy[1]), .done(done[1]), .table_code(code[1]), .unstable(unstable[1])
  );

  // Gate models; GLITCH flips the second sample of row 3 (age 6 with 4+2 timing).
  function automatic logic gate_model(int m, logic [2:0] r, int ag);
    case (m)
      M_AND13:  return r[2] & r[0];
      M_ZERO:   return 1'b0;
      M_ONE:    return 1'b1;
      M_XOR3:   return ^r;
      M_GLITCH: return (r[2] & r[0]) ^ (r == 3'd3 && ag == 6);
      default:  return 1'b0;
    endcase
  endfunction

  assign dut_out[0] = gate_model(mode[0], {in1[0], in2[0], in3[0]}, age[0]);
  assign dut_out[1] = gate_model(mode[1], {in1[1], in2[1], in3[1]}, age[1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: row-sequence checks during busy, scoreboard pop on every done.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [2:0] r;
      exp_t e;
      r = {in1[i], in2[i], in3[i]};
      if (r != last_row[i]) begin
        last_row[i] = r;
        age[i] = 1;
      end else begin
        age[i]++;
      end
      if (reset) begin
        prev_busy[i] = 1'b0;
        prev_done[i] = 1'b0;
        busy_cnt[i]  = 0;
      end else begin
        if (busy[i]) begin
          if (!prev_busy[i]) chk("first_row", r, 3'd0);
          else if (r != busy_row[i]) chk("row_step", r, 3'(busy_row[i] + 3'd1));
          busy_row[i] = r;
          busy_cnt[i]++;
        end
        if (done[i]) begin
          if (prev_done[i]) begin
            checks++; failures++;
            $display("FAIL done_width inst=%0d actual=2+cycles required=1", i);
          end
          if (sb[i].size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done inst=%0d actual=done required=none", i);
          end else begin
            e = sb[i].pop_front();
            chk("table_code", code[i], e.code);
            chk("unstable", unstable[i], e.unst);
            chk("done_cycle", cyc, e.done_cyc);
            chk("busy_len", busy_cnt[i], e.busy_len);
            chk("busy_at_done", busy[i], 1'b0);
          end
          busy_cnt[i] = 0;
        end
        prev_busy[i] = busy[i];
        prev_done[i] = done[i];
      end
    end
  end

  task automatic do_start(input int i, input int m, input logic [7:0] c, input logic u);
    exp_t e;
    mode[i] = m;
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
    e.code = c;
    e.unst = u;
    e.busy_len = 8 * ((i == 0) ? 6 : 2);
    e.done_cyc = cyc + e.busy_len;
    sb[i].push_back(e);
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (sb[i].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb[i].size() != 0) begin
      checks++; failures++;
      $display("FAIL done_timeout inst=%0d actual=no_done required=done", i);
      sb[i].delete();
    end
  endtask

  task automatic chk_reset_state(input int i);
    chk("reset_rows", {in1[i], in2[i], in3[i]}, 3'd0);
    chk("reset_busy_done", {busy[i], done[i]}, 2'b00);
    chk("reset_table", code[i], 8'h00);
    chk("reset_unstable", unstable[i], 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; mode[i] = M_AND13; age[i] = 0; last_row[i] = 3'd0;
      busy_cnt[i] = 0; prev_busy[i] = 1'b0; prev_done[i] = 1'b0; busy_row[i] = 3'd0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);

    do_start(0, M_AND13, 8'h05, 1'b0);
    wait_done(0);
    repeat (5) @(negedge clk);
    chk("retain_table", code[0], 8'h05);
    chk("rows_hold_111", {in1[0], in2[0], in3[0]}, 3'd7);

    do_start(0, M_ZERO, 8'h00, 1'b0);
    wait_done(0);
    do_start(0, M_ONE, 8'hFF, 1'b0);
    wait_done(0);
    do_start(0, M_GLITCH, 8'h05, 1'b1);
    wait_done(0);
    chk("unstable_retained", unstable[0], 1'b1);

    // Start hammered for 40 of the 48 busy cycles: one sweep, one done.
    do_start(0, M_XOR3, 8'h69, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk) start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
    end
    wait_done(0);
    repeat (4) @(negedge clk);
    chk("no_requeue_busy", busy[0], 1'b0);

    do_start(0, M_AND13, 8'h05, 1'b0);
    n = 0;
    while ({in1[0], in2[0], in3[0]} != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_row4", {in1[0], in2[0], in3[0]}, 3'd4);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state(0);
    reset = 1'b0;
    sb[0].delete();
    repeat (3) @(negedge clk);
    chk("idle_after_reset", busy[0], 1'b0);
    do_start(0, M_ONE, 8'hFF, 1'b0);
    wait_done(0);

    do_start(1, M_XOR3, 8'h69, 1'b0);
    wait_done(1);
    do_start(1, M_AND13, 8'h05, 1'b0);
    wait_done(1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
